// File: rtl/spectag_recovery_ctrl_if.sv
// Resolution/allocation bus between dispatch, the branch unit and spectag_recovery_ctrl.
// The master drives requests and resolutions; the slave is the tag tracker.
interface spectag_recovery_ctrl_if #(
  parameter int SPECTAG_LEN = 5,
  parameter int ADDR_LEN    = 32
);
  logic                   alloc_req;
  logic                   alloc_gnt;
  logic [SPECTAG_LEN-1:0] alloc_tag;
  logic                   prsuccess;
  logic                   prmiss;
  logic [SPECTAG_LEN-1:0] br_spectag;
  logic [ADDR_LEN-1:0]    jmpaddr;
  logic                   redirect_valid;
  logic [ADDR_LEN-1:0]    redirect_pc;
  logic [SPECTAG_LEN-1:0] kill_mask;
  logic [SPECTAG_LEN-1:0] clear_mask;
  logic                   stall_fetch;
  logic [SPECTAG_LEN-1:0] live_tags;
  logic                   tag_err;

  modport master (
    output alloc_req, prsuccess, prmiss, br_spectag, jmpaddr,
    input  alloc_gnt, alloc_tag, redirect_valid, redirect_pc, kill_mask,
           clear_mask, stall_fetch, live_tags, tag_err
  );

  modport slave (
    input  alloc_req, prsuccess, prmiss, br_spectag, jmpaddr,
    output alloc_gnt, alloc_tag, redirect_valid, redirect_pc, kill_mask,
           clear_mask, stall_fetch, live_tags, tag_err
  );
endinterface

// File: rtl/spectag_recovery_ctrl.sv
// Speculative tag allocator and branch-resolution recovery controller.
// Define SPECTAG_REDIRECT_REG_EN to register redirect/kill/clear outputs one cycle later.
module spectag_recovery_ctrl #(
  parameter int SPECTAG_LEN  = 5,
  parameter int ADDR_LEN     = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  spectag_recovery_ctrl_if.slave  bus
);
  localparam int CNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                 r_state, w_stateNext;
  logic [CNT_W-1:0]       r_cnt, w_cntNext;
  logic [SPECTAG_LEN-1:0] r_live, w_liveNext;
  logic [SPECTAG_LEN-1:0] r_next, w_nextNext;
  logic                   r_tagErr, w_tagErrNext;

  logic                   w_oneHot, w_tagLive, w_validMiss, w_validSucc, w_err;
  logic                   w_allocGnt;
  logic [SPECTAG_LEN-1:0] w_younger, w_kill, w_walk;
  logic                   w_stop;

  assign w_oneHot    = (bus.br_spectag != '0) &&
                       ((bus.br_spectag & (bus.br_spectag - 1'b1)) == '0);
  assign w_tagLive   = w_oneHot && ((bus.br_spectag & r_live) != '0);
  assign w_validMiss = bus.prmiss && !bus.prsuccess && w_tagLive;
  assign w_validSucc = bus.prsuccess && !bus.prmiss && w_tagLive;
  assign w_err       = (bus.prmiss || bus.prsuccess) && !(w_validMiss || w_validSucc);
  assign w_allocGnt  = bus.alloc_req && (r_state == IDLE) && !bus.prmiss &&
                       ((r_live & r_next) == '0);

  // Younger tags sit between the resolving tag and the next free slot, walking left.
  always_comb begin
    w_younger = '0;
    w_walk    = bus.br_spectag;
    w_stop    = 1'b0;
    for (int i = 1; i < SPECTAG_LEN; i++) begin
      w_walk = {w_walk[SPECTAG_LEN-2:0], w_walk[SPECTAG_LEN-1]};
      if (w_walk == r_next) w_stop = 1'b1;
      if (!w_stop) w_younger = w_younger | (w_walk & r_live);
    end
  end

  assign w_kill = bus.br_spectag | w_younger;

  // A mispredict overrides allocation and free in the same cycle.
  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_cnt;
    w_liveNext   = r_live;
    w_nextNext   = r_next;
    w_tagErrNext = r_tagErr | w_err;
    if (w_allocGnt) begin
      w_liveNext = w_liveNext | r_next;
      w_nextNext = {r_next[SPECTAG_LEN-2:0], r_next[SPECTAG_LEN-1]};
    end
    if (w_validSucc) w_liveNext = w_liveNext & ~bus.br_spectag;
    if (r_state == FLUSH) begin
      if (r_cnt == '0) w_stateNext = IDLE;
      else             w_cntNext   = r_cnt - 1'b1;
    end
    if (w_validMiss) begin
      w_liveNext  = r_live & ~w_kill;
      w_nextNext  = bus.br_spectag;
      w_stateNext = FLUSH;
      w_cntNext   = FLUSH_INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_live   <= '0;
      r_next   <= SPECTAG_LEN'(1);
      r_tagErr <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      r_live   <= w_liveNext;
      r_next   <= w_nextNext;
      r_tagErr <= w_tagErrNext;
    end
  end

  assign bus.alloc_gnt = w_allocGnt;
  assign bus.alloc_tag = r_next;
  assign bus.live_tags = r_live;
  assign bus.tag_err   = r_tagErr;

`ifdef SPECTAG_REDIRECT_REG_EN
  logic                   r_redirValid;
  logic [ADDR_LEN-1:0]    r_redirPc;
  logic [SPECTAG_LEN-1:0] r_killMask, r_clearMask;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_redirValid <= 1'b0;
      r_redirPc    <= '0;
      r_killMask   <= '0;
      r_clearMask  <= '0;
    end else begin
      r_redirValid <= w_validMiss;
      r_redirPc    <= w_validMiss ? bus.jmpaddr : '0;
      r_killMask   <= w_validMiss ? w_kill : '0;
      r_clearMask  <= w_validSucc ? bus.br_spectag : '0;
    end
  end

  assign bus.redirect_valid = r_redirValid;
  assign bus.redirect_pc    = r_redirPc;
  assign bus.kill_mask      = r_killMask;
  assign bus.clear_mask     = r_clearMask;
  assign bus.stall_fetch    = (r_state == FLUSH) || w_validMiss;
`else
  assign bus.redirect_valid = w_validMiss;
  assign bus.redirect_pc    = w_validMiss ? bus.jmpaddr : '0;
  assign bus.kill_mask      = w_validMiss ? w_kill : '0;
  assign bus.clear_mask     = w_validSucc ? bus.br_spectag : '0;
  assign bus.stall_fetch    = (r_state == FLUSH);
`endif
endmodule

// File: tb/tb_spectag_recovery_ctrl.sv
// Directed vector bench for spectag_recovery_ctrl in its default (combinational redirect) build.
// One record per clock cycle: inputs driven after the falling edge, outputs sampled before the rising edge.
module tb_spectag_recovery_ctrl;
  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  spectag_recovery_ctrl_if #(.SPECTAG_LEN(5), .ADDR_LEN(32)) bus ();

  spectag_recovery_ctrl #(
    .SPECTAG_LEN(5), .ADDR_LEN(32), .FLUSH_CYCLES(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          chk;
    bit          alloc;
    bit          succ;
    bit          miss;
    logic [4:0]  tag;
    logic [31:0] addr;
    bit          gnt;
    logic [4:0]  atag;
    bit          rv;
    logic [31:0] pc;
    logic [4:0]  kill;
    logic [4:0]  clr;
    bit          stall;
    logic [4:0]  live;
    bit          err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit chk, bit alloc, bit succ, bit miss,
                              logic [4:0] tag, logic [31:0] addr, bit gnt,
                              logic [4:0] atag, bit rv, logic [31:0] pc,
                              logic [4:0] kill, logic [4:0] clr, bit stall,
                              logic [4:0] live, bit err);
    vec_t v;
    v.rst = rst; v.chk = chk; v.alloc = alloc; v.succ = succ; v.miss = miss;
    v.tag = tag; v.addr = addr; v.gnt = gnt; v.atag = atag; v.rv = rv;
    v.pc = pc; v.kill = kill; v.clr = clr; v.stall = stall; v.live = live;
    v.err = err;
    return v;
  endfunction

  function automatic vec_t rstRow();
    return mk(1, 0, 0, 0, 0, 5'b0, 32'h0, 0, 5'b0, 0, 32'h0, 5'b0, 5'b0, 0, 5'b0, 0);
  endfunction

  task automatic checkOutput(input string name, input int row,
                             input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL row %0d %s: got 0x%0h expected 0x%0h", row, name, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int row);
    @(negedge clk);
    reset          = v.rst;
    bus.alloc_req  = v.alloc;
    bus.prsuccess  = v.succ;
    bus.prmiss     = v.miss;
    bus.br_spectag = v.tag;
    bus.jmpaddr    = v.addr;
    #2;
    if (v.chk) begin
      checkOutput("alloc_gnt",      row, 32'(bus.alloc_gnt),      32'(v.gnt));
      checkOutput("alloc_tag",      row, 32'(bus.alloc_tag),      32'(v.atag));
      checkOutput("redirect_valid", row, 32'(bus.redirect_valid), 32'(v.rv));
      checkOutput("redirect_pc",    row, bus.redirect_pc,         v.pc);
      checkOutput("kill_mask",      row, 32'(bus.kill_mask),      32'(v.kill));
      checkOutput("clear_mask",     row, 32'(bus.clear_mask),     32'(v.clr));
      checkOutput("stall_fetch",    row, 32'(bus.stall_fetch),    32'(v.stall));
      checkOutput("live_tags",      row, 32'(bus.live_tags),      32'(v.live));
      checkOutput("tag_err",        row, 32'(bus.tag_err),        32'(v.err));
    end
  endtask

  initial begin
    compared       = 0;
    mismatched     = 0;
    reset          = 1'b1;
    bus.alloc_req  = 1'b0;
    bus.prsuccess  = 1'b0;
    bus.prmiss     = 1'b0;
    bus.br_spectag = '0;
    bus.jmpaddr    = '0;
    repeat (2) @(posedge clk);

    // Reset state, then fill all five tags and see the sixth request refused.
    vecs.push_back(mk(0,1, 0,0,0, 5'b00000, 32'h0,    0, 5'b00001, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00000, 0));
    vecs.push_back(mk(0,1, 1,0,0, 5'b00000, 32'h0,    1, 5'b00001, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00000, 0));
    vecs.push_back(mk(0,1, 1,0,0, 5'b00000, 32'h0,    1, 5'b00010, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00001, 0));
    vecs.push_back(mk(0,1, 1,0,0, 5'b00000, 32'h0,    1, 5'b00100, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00011, 0));
    vecs.push_back(mk(0,1, 1,0,0, 5'b00000, 32'h0,    1, 5'b01000, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00111, 0));
    vecs.push_back(mk(0,1, 1,0,0, 5'b00000, 32'h0,    1, 5'b10000, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b01111, 0));
    vecs.push_back(mk(0,1, 1,0,0, 5'b00000, 32'h0,    0, 5'b00001, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b11111, 0));
    // Correct prediction frees only its own tag.
    vecs.push_back(rstRow());
    vecs.push_back(mk(0,1, 1,0,0, 5'b00000, 32'h0,    1, 5'b00001, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00000, 0));
    vecs.push_back(mk(0,1, 1,0,0, 5'b00000, 32'h0,    1, 5'b00010, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00001, 0));
    vecs.push_back(mk(0,1, 1,0,0, 5'b00000, 32'h0,    1, 5'b00100, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00011, 0));
    vecs.push_back(mk(0,1, 0,1,0, 5'b00010, 32'h0,    0, 5'b01000, 0, 32'h0, 5'b00000, 5'b00010, 0, 5'b00111, 0));
    vecs.push_back(mk(0,1, 0,0,0, 5'b00000, 32'h0,    0, 5'b01000, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00101, 0));
    // Mispredict kills younger tags, stalls two cycles, then reuses the killed tag first.
    vecs.push_back(rstRow());
    vecs.push_back(mk(0,1, 1,0,0, 5'b00000, 32'h0,    1, 5'b00001, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00000, 0));
    vecs.push_back(mk(0,1, 1,0,0, 5'b00000, 32'h0,    1, 5'b00010, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00001, 0));
    vecs.push_back(mk(0,1, 1,0,0, 5'b00000, 32'h0,    1, 5'b00100, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00011, 0));
    vecs.push_back(mk(0,1, 1,0,0, 5'b00000, 32'h0,    1, 5'b01000, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00111, 0));
    vecs.push_back(mk(0,1, 0,0,1, 5'b00010, 32'h1000, 0, 5'b10000, 1, 32'h1000, 5'b01110, 5'b00000, 0, 5'b01111, 0));
    vecs.push_back(mk(0,1, 1,0,0, 5'b00000, 32'h0,    0, 5'b00010, 0, 32'h0, 5'b00000, 5'b00000, 1, 5'b00001, 0));
    vecs.push_back(mk(0,1, 1,0,0, 5'b00000, 32'h0,    0, 5'b00010, 0, 32'h0, 5'b00000, 5'b00000, 1, 5'b00001, 0));
    vecs.push_back(mk(0,1, 1,0,0, 5'b00000, 32'h0,    1, 5'b00010, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00001, 0));
    // Wrapped ring: oldest is 01000, youngest 00001, so missing on 10000 kills 10001.
    vecs.push_back(rstRow());
    vecs.push_back(mk(0,1, 1,0,0, 5'b00000, 32'h0,    1, 5'b00001, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00000, 0));
    vecs.push_back(mk(0,1, 1,0,0, 5'b00000, 32'h0,    1, 5'b00010, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00001, 0));
    vecs.push_back(mk(0,1, 1,0,0, 5'b00000, 32'h0,    1, 5'b00100, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00011, 0));
    vecs.push_back(mk(0,1, 1,0,0, 5'b00000, 32'h0,    1, 5'b01000, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00111, 0));
    vecs.push_back(mk(0,1, 1,0,0, 5'b00000, 32'h0,    1, 5'b10000, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b01111, 0));
    vecs.push_back(mk(0,1, 0,1,0, 5'b00001, 32'h0,    0, 5'b00001, 0, 32'h0, 5'b00000, 5'b00001, 0, 5'b11111, 0));
    vecs.push_back(mk(0,1, 1,1,0, 5'b00010, 32'h0,    1, 5'b00001, 0, 32'h0, 5'b00000, 5'b00010, 0, 5'b11110, 0));
    vecs.push_back(mk(0,1, 0,1,0, 5'b00100, 32'h0,    0, 5'b00010, 0, 32'h0, 5'b00000, 5'b00100, 0, 5'b11101, 0));
    vecs.push_back(mk(0,1, 0,0,1, 5'b10000, 32'h2000, 0, 5'b00010, 1, 32'h2000, 5'b10001, 5'b00000, 0, 5'b11001, 0));
    vecs.push_back(mk(0,1, 0,0,0, 5'b00000, 32'h0,    0, 5'b10000, 0, 32'h0, 5'b00000, 5'b00000, 1, 5'b01000, 0));
    vecs.push_back(mk(0,1, 0,0,0, 5'b00000, 32'h0,    0, 5'b10000, 0, 32'h0, 5'b00000, 5'b00000, 1, 5'b01000, 0));
    // Mispredict beats a same-cycle allocation; a free on a dead tag sets the sticky error.
    vecs.push_back(mk(0,1, 1,0,1, 5'b01000, 32'h3000, 0, 5'b10000, 1, 32'h3000, 5'b01000, 5'b00000, 0, 5'b01000, 0));
    vecs.push_back(mk(0,1, 0,1,0, 5'b00100, 32'h0,    0, 5'b01000, 0, 32'h0, 5'b00000, 5'b00000, 1, 5'b00000, 0));
    vecs.push_back(mk(0,1, 0,0,0, 5'b00000, 32'h0,    0, 5'b01000, 0, 32'h0, 5'b00000, 5'b00000, 1, 5'b00000, 1));
    vecs.push_back(mk(0,1, 0,0,0, 5'b00000, 32'h0,    0, 5'b01000, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00000, 1));

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    // Reset landing in the middle of a flush window.
    applyStimulus(rstRow(), 100);
    applyStimulus(mk(0,1, 1,0,0, 5'b00000, 32'h0,  1, 5'b00001, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00000, 0), 101);
    applyStimulus(mk(0,1, 1,0,0, 5'b00000, 32'h0,  1, 5'b00010, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00001, 0), 102);
    applyStimulus(mk(0,1, 0,0,1, 5'b00001, 32'h40, 0, 5'b00100, 1, 32'h40, 5'b00011, 5'b00000, 0, 5'b00011, 0), 103);
    applyStimulus(mk(1,1, 0,0,0, 5'b00000, 32'h0,  0, 5'b00001, 0, 32'h0, 5'b00000, 5'b00000, 1, 5'b00000, 0), 104);
    applyStimulus(mk(0,1, 0,0,0, 5'b00000, 32'h0,  0, 5'b00001, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00000, 0), 105);

    // Both strobes together on a live tag: nothing changes except the error flag.
    applyStimulus(mk(0,1, 1,0,0, 5'b00000, 32'h0,  1, 5'b00001, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00000, 0), 106);
    applyStimulus(mk(0,1, 0,1,1, 5'b00001, 32'h80, 0, 5'b00010, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00001, 0), 107);
    applyStimulus(mk(0,1, 0,0,0, 5'b00000, 32'h0,  0, 5'b00010, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00001, 1), 108);

    // Non-one-hot tag with a strobe is treated as dead after a fresh reset.
    applyStimulus(rstRow(), 109);
    applyStimulus(mk(0,1, 1,0,0, 5'b00000, 32'h0,  1, 5'b00001, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00000, 0), 110);
    applyStimulus(mk(0,1, 1,0,0, 5'b00000, 32'h0,  1, 5'b00010, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00001, 0), 111);
    applyStimulus(mk(0,1, 0,0,1, 5'b00011, 32'h90, 0, 5'b00100, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00011, 0), 112);
    applyStimulus(mk(0,1, 0,0,0, 5'b00000, 32'h0,  0, 5'b00100, 0, 32'h0, 5'b00000, 5'b00000, 0, 5'b00011, 1), 113);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
